// File: rtl/spi_master.sv
// SPI mode-0 master: MSB-first byte transfers with full-duplex receive and
// multi-byte frames that hold chip select low until a byte flagged last.
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tx_vld_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  output logic       tx_rdy_o,
  output logic       rx_vld_o,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o,
  output logic       spi_cs_n_o,
  input  logic       spi_miso_i
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HALF_W = 5;
  localparam logic [DIV_W-1:0]  DIV_MAX        = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST_FALL = HALF_W'(15);
  localparam logic [HALF_W-1:0] HALF_DONE      = HALF_W'(16);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_NEXT  = 3'd3,
    S_END   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [6:0]        tx_sr_q, tx_sr_d;   // bits still to send after the one on MOSI
  logic [7:0]        rx_sr_q, rx_sr_d;
  logic              last_q, last_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              rx_vld_q, rx_vld_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              tx_rdy_q, tx_rdy_d;
  logic              busy_q, busy_d;
  logic              miso_q;
  logic              accept;
  logic              tick;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      half_q    <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      last_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      rx_vld_q  <= 1'b0;
      rx_data_q <= '0;
      tx_rdy_q  <= 1'b1;
      busy_q    <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      half_q    <= half_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      last_q    <= last_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      rx_vld_q  <= rx_vld_d;
      rx_data_q <= rx_data_d;
      tx_rdy_q  <= tx_rdy_d;
      busy_q    <= busy_d;
      miso_q    <= spi_miso_i;
    end
  end

  // Next-state, SCLK generation and shift logic
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    last_d    = last_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    rx_vld_d  = 1'b0;
    rx_data_d = rx_data_q;
    accept    = tx_vld_i & tx_rdy_q;
    tick      = (div_q == DIV_MAX);

    case (state_q)
      S_IDLE, S_NEXT: begin
        if (accept) begin
          state_d = S_SETUP;
          div_d   = '0;
          tx_sr_d = tx_data_i[6:0];
          last_d  = tx_last_i;
          mosi_d  = tx_data_i[7];
          cs_n_d  = 1'b0;
        end
      end
      S_SETUP: begin
        if (tick) begin
          state_d = S_XFER;
          div_d   = '0;
          half_d  = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_XFER: begin
        // First cycle of each high phase: miso_q holds MISO taken at the rise
        if (sclk_q && (div_q == '0)) begin
          rx_sr_d = {rx_sr_q[6:0], miso_q};
        end
        if (half_q == HALF_DONE) begin
          rx_data_d = rx_sr_q;
          rx_vld_d  = 1'b1;
          half_d    = '0;
          div_d     = '0;
          if (last_q) begin
            state_d = S_END;
            cs_n_d  = 1'b1;
          end else begin
            state_d = S_NEXT;
          end
        end else if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          half_d = half_q + HALF_W'(1);
          if (sclk_q && (half_q != HALF_LAST_FALL)) begin
            mosi_d  = tx_sr_q[6];
            tx_sr_d = {tx_sr_q[5:0], 1'b0};
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_END: begin
        if (tick) begin
          state_d = S_IDLE;
          div_d   = '0;
          mosi_d  = 1'b0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase

    tx_rdy_d = (state_d == S_IDLE) || (state_d == S_NEXT);
    busy_d   = (state_d != S_IDLE);
  end

  assign tx_rdy_o   = tx_rdy_q;
  assign rx_vld_o   = rx_vld_q;
  assign rx_data_o  = rx_data_q;
  assign busy_o     = busy_q;
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;
  assign spi_cs_n_o = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus pushes expected bytes, a monitor
// checks every rx_vld_o pulse, and a mode-0 slave model drives MISO.
module tb_spi_master;

  localparam int unsigned DIV = 2;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, rst1_n;
  logic       tx_vld, tx_last, tx_rdy, rx_vld, busy, sclk, mosi, cs_n, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_vld1, tx_last1, tx_rdy1, rx_vld1, busy1, sclk1, mosi1, cs_n1;
  logic [7:0] tx_data1, rx_data1;
  logic       miso1 = 1'b1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  // slave model state
  logic [7:0] slv_q[$];
  logic [7:0] obs_q[$];
  int         slv_cnt = 0;
  logic [7:0] slv_sh = '0;
  logic [7:0] slv_cur;

  // monitor state
  logic       mon_en = 1'b0;
  logic       prev_sclk = 1'b0;
  logic       prev_cs = 1'b1;
  int         hi_run = 0;
  int         since_fall = 0;
  int         rises = 0;
  int         cs_rises = 0;
  exp_t       mon_e;
  logic [7:0] mon_obs;

  spi_master #(.CLK_DIV(DIV)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .tx_vld_i(tx_vld), .tx_data_i(tx_data),
    .tx_last_i(tx_last), .tx_rdy_o(tx_rdy), .rx_vld_o(rx_vld), .rx_data_o(rx_data),
    .busy_o(busy), .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_cs_n_o(cs_n),
    .spi_miso_i(miso)
  );

  spi_master #(.CLK_DIV(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst1_n), .tx_vld_i(tx_vld1), .tx_data_i(tx_data1),
    .tx_last_i(tx_last1), .tx_rdy_o(tx_rdy1), .rx_vld_o(rx_vld1), .rx_data_o(rx_data1),
    .busy_o(busy1), .spi_sclk_o(sclk1), .spi_mosi_o(mosi1), .spi_cs_n_o(cs_n1),
    .spi_miso_i(miso1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: mode 0, shifts on SCLK fall, captures MOSI on SCLK rise
  always @(negedge cs_n) slv_cnt = 0;
  always @(posedge sclk) if (!cs_n) slv_sh = {slv_sh[6:0], mosi};
  always @(negedge sclk) begin
    if (!cs_n) begin
      if (slv_cnt == 7) begin
        slv_cnt = 0;
        obs_q.push_back(slv_sh);
        if (slv_q.size() > 0) void'(slv_q.pop_front());
      end else begin
        slv_cnt++;
      end
    end
  end
  always @(negedge clk) begin
    slv_cur = (slv_q.size() > 0) ? slv_q[0] : 8'h00;
    miso <= slv_cur[3'(7 - slv_cnt)];
  end

  // Monitor: scoreboard pops on rx_vld, SCLK high width, last fall to CS rise
  always @(negedge clk) begin
    if (mon_en) begin
      if (rx_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rx_vld", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rx_data", int'(rx_data), int'(mon_e.rx));
          chk("latency", cyc - mon_e.acc - 1, 1 + 17 * DIV);
          if (obs_q.size() == 0) begin
            chk("mosi_missing", 1, 0);
          end else begin
            mon_obs = obs_q.pop_front();
            chk("mosi_byte", int'(mon_obs), int'(mon_e.tx));
          end
        end
      end
      if (sclk) hi_run++;
      if (sclk && !prev_sclk) rises++;
      if (!sclk && prev_sclk) begin
        chk("sclk_high", hi_run, DIV);
        hi_run = 0;
        since_fall = 0;
      end else begin
        since_fall++;
      end
      if (cs_n && !prev_cs) begin
        cs_rises++;
        chk("fall_to_cs", since_fall, 1);
      end
    end else begin
      hi_run = 0;
      since_fall = 0;
    end
    prev_sclk = sclk;
    prev_cs   = cs_n;
  end

  task automatic send(input logic [7:0] tx, input logic [7:0] rx, input logic last);
    int n;
    slv_q.push_back(rx);
    @(negedge clk);
    tx_vld = 1'b1; tx_data = tx; tx_last = last;
    n = 0;
    while (!tx_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!tx_rdy) chk("accept_timeout", 1, 0);
    @(posedge clk);
    exp_q.push_back('{tx: tx, rx: rx, acc: cyc});
  endtask

  task automatic wait_rx();
    int n;
    n = 0;
    while (!rx_vld && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!rx_vld) chk("rx_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
    @(negedge clk);
  endtask

  task automatic wait_rises(input int target);
    int n;
    n = 0;
    while (rises < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (rises < target) chk("rise_timeout", rises, target);
  endtask

  initial begin
    int n, r0, c0, bad, a, last_rise, rises1;
    logic [7:0] sh;
    logic prev;
    rst_n = 1'b0; rst1_n = 1'b0;
    tx_vld = 1'b0; tx_data = '0; tx_last = 1'b0;
    tx_vld1 = 1'b0; tx_data1 = '0; tx_last1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_mosi", int'(mosi), 0);
    chk("rst_tx_rdy", int'(tx_rdy), 1);
    chk("rst_rx_vld", int'(rx_vld), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1; rst1_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // single byte, last
    r0 = rises; c0 = cs_rises;
    send(8'hA5, 8'h3C, 1'b1);
    #1 tx_vld = 1'b0;
    wait_rx();
    n = 0;
    while (!tx_rdy && n < 50) begin
      if (cs_n) n++;
      @(negedge clk);
    end
    chk("cs_deselect_cycles", n, DIV);
    chk("idle_mosi", int'(mosi), 0);
    chk("idle_cs_n", int'(cs_n), 1);
    chk("t1_rises", rises - r0, 8);
    chk("t1_cs_rises", cs_rises - c0, 1);

    // back-to-back frame with tx_vld held high
    r0 = rises; c0 = cs_rises;
    send(8'h01, 8'hE7, 1'b0);
    send(8'hFF, 8'h18, 1'b1);
    #1 tx_vld = 1'b0;
    wait_idle();
    chk("t2_rises", rises - r0, 16);
    chk("t2_cs_rises", cs_rises - c0, 1);

    // stall between bytes
    r0 = rises;
    send(8'h55, 8'hC6, 1'b0);
    #1 tx_vld = 1'b0;
    wait_rx();
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (cs_n || sclk || !tx_rdy) bad++;
    end
    chk("stall_hold", bad, 0);
    send(8'hAA, 8'h5B, 1'b1);
    #1 tx_vld = 1'b0;
    wait_idle();
    chk("t3_rises", rises - r0, 16);

    // request during XFER is ignored
    r0 = rises;
    send(8'h96, 8'h69, 1'b1);
    #1 tx_vld = 1'b0;
    wait_rises(r0 + 2);
    @(negedge clk);
    tx_vld = 1'b1; tx_data = 8'h12; tx_last = 1'b0;
    repeat (10) @(negedge clk);
    tx_vld = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    chk("t4_no_extra_busy", int'(busy), 0);
    chk("t4_rises", rises - r0, 8);

    // reset mid-byte
    r0 = rises;
    send(8'h5A, 8'hF0, 1'b1);
    #1 tx_vld = 1'b0;
    wait_rises(r0 + 4);
    @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", int'(cs_n), 1);
    chk("mid_rst_sclk", int'(sclk), 0);
    chk("mid_rst_mosi", int'(mosi), 0);
    chk("mid_rst_rx_vld", int'(rx_vld), 0);
    chk("mid_rst_tx_rdy", int'(tx_rdy), 1);
    exp_q.delete(); slv_q.delete(); obs_q.delete(); slv_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    send(8'hC3, 8'h81, 1'b1);
    #1 tx_vld = 1'b0;
    wait_idle();

    // CLK_DIV = 1 instance, MISO tied high
    @(negedge clk);
    tx_vld1 = 1'b1; tx_data1 = 8'h80; tx_last1 = 1'b1;
    @(posedge clk);
    a = cyc;
    #1 tx_vld1 = 1'b0;
    n = 0; rises1 = 0; bad = 0; last_rise = -1; sh = '0; prev = sclk1;
    while (!rx_vld1 && n < 100) begin
      @(negedge clk);
      n++;
      if (sclk1 && !prev) begin
        if (last_rise >= 0 && (n - last_rise) != 2) bad++;
        last_rise = n;
        rises1++;
        sh = {sh[6:0], mosi1};
      end
      prev = sclk1;
    end
    chk("d1_latency", cyc - a - 1, 18);
    chk("d1_rx_data", int'(rx_data1), 8'hFF);
    chk("d1_rises", rises1, 8);
    chk("d1_period", bad, 0);
    chk("d1_mosi_byte", int'(sh), 8'h80);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
